// File: rtl/pattern_sequencer_pkg.sv
// Shared video definitions: pattern index width, sequencer state encodings
// and the wrap-around step helper used by the sequencer and pattern generator.
package pattern_sequencer_pkg;

  localparam int PATTERN_W   = 4;
  localparam int FRAME_CNT_W = 16;

  typedef logic [PATTERN_W-1:0] pattern_t;

  // state    | meaning
  // ST_SHOW  | pattern displayed, manual/auto requests accepted
  // ST_PEND  | manual change held until the next frame strobe
  // ST_BLANK | output forced black for the configured number of frames
  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } seq_state_t;

  typedef enum logic {
    DIR_PREV = 1'b0,
    DIR_NEXT = 1'b1
  } step_dir_t;

  function automatic pattern_t step_pattern(input pattern_t cur, input step_dir_t dir,
                                            input pattern_t lo, input pattern_t hi);
    pattern_t res;
    res = cur;
    if (dir == DIR_NEXT) begin
      if (cur >= hi) res = lo;
      else           res = cur + pattern_t'(1);
    end else begin
      if (cur <= lo) res = hi;
      else           res = cur - pattern_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control/status bundle between the front-panel logic and the pattern sequencer.
interface pattern_sequencer_if;
  import pattern_sequencer_pkg::*;

  logic     i_frame_strobe;
  logic     i_next;
  logic     i_prev;
  logic     i_mode;
  pattern_t o_pattern;
  logic     o_blank;
  logic     o_auto;
  logic     o_changed;

  modport master (
    output i_frame_strobe, i_next, i_prev, i_mode,
    input  o_pattern, o_blank, o_auto, o_changed
  );

  modport slave (
    input  i_frame_strobe, i_next, i_prev, i_mode,
    output o_pattern, o_blank, o_auto, o_changed
  );

endinterface

// File: rtl/pattern_sequencer_frame_counter.sv
// Strobe-driven down-counter; o_tc flags that the next enabled strobe is the
// TERMINAL-th one, after which the count reloads by itself.
module frame_counter #(
  parameter int WIDTH    = 16,
  parameter int TERMINAL = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] LP_LOAD = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_remaining;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_remaining <= LP_LOAD;
    end else if (i_enable) begin
      if (r_remaining <= LP_ONE) r_remaining <= LP_LOAD;
      else                       r_remaining <= r_remaining - LP_ONE;
    end
  end

  assign o_tc = (r_remaining == LP_ONE);

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: manual next/prev stepping aligned to frame strobes,
// optional auto-advance after a dwell time, and black blanking after each change.
module pattern_sequencer #(
  parameter int MIN_PATTERN   = 1,
  parameter int MAX_PATTERN   = 8,
  parameter int RESET_PATTERN = 1,
  parameter int DWELL_FRAMES  = 120,
  parameter int BLANK_FRAMES  = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  pattern_sequencer_if.slave bus
);
  import pattern_sequencer_pkg::*;

  localparam pattern_t LP_MIN      = pattern_t'(MIN_PATTERN);
  localparam pattern_t LP_MAX      = pattern_t'(MAX_PATTERN);
  localparam pattern_t LP_RESET    = pattern_t'(RESET_PATTERN);
  localparam int       LP_DWELL_TC = (DWELL_FRAMES > 0) ? DWELL_FRAMES : 1;
  localparam int       LP_BLANK_TC = (BLANK_FRAMES > 0) ? BLANK_FRAMES : 1;
  localparam bit       LP_BLANKING = (BLANK_FRAMES > 0);

  seq_state_t r_state, w_state_next;
  step_dir_t  r_dir, w_dir_next;
  pattern_t   r_pattern;
  logic       r_blank;
  logic       r_auto;
  logic       r_changed;

  logic       w_strobe;
  logic       w_req_next;
  logic       w_req_prev;
  logic       w_req;
  step_dir_t  w_req_dir;
  logic       w_step;
  step_dir_t  w_step_dir;
  logic       w_dwell_tc;
  logic       w_dwell_clear;
  logic       w_dwell_en;
  logic       w_blank_tc;
  logic       w_blank_clear;
  logic       w_blank_en;

  // Simultaneous next and prev cancel each other out.
  assign w_strobe   = bus.i_frame_strobe;
  assign w_req_next = bus.i_next & ~bus.i_prev;
  assign w_req_prev = bus.i_prev & ~bus.i_next;
  assign w_req      = w_req_next | w_req_prev;
  assign w_req_dir  = w_req_next ? DIR_NEXT : DIR_PREV;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_SHOW;
      r_dir   <= DIR_NEXT;
    end else begin
      r_state <= w_state_next;
      r_dir   <= w_dir_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir;
    w_step       = 1'b0;
    w_step_dir   = DIR_NEXT;
    case (r_state)
      ST_SHOW: begin
        // A manual request on a dwell-expiry strobe takes precedence.
        if (w_req) begin
          if (w_strobe) begin
            w_step     = 1'b1;
            w_step_dir = w_req_dir;
          end else begin
            w_state_next = ST_PEND;
            w_dir_next   = w_req_dir;
          end
        end else if (w_strobe && r_auto && w_dwell_tc) begin
          w_step     = 1'b1;
          w_step_dir = DIR_NEXT;
        end
      end
      ST_PEND: begin
        if (w_req && (w_req_dir != r_dir)) begin
          w_state_next = ST_SHOW;
        end else if (w_strobe) begin
          w_step     = 1'b1;
          w_step_dir = r_dir;
        end
      end
      ST_BLANK: begin
        if (w_strobe && w_blank_tc) w_state_next = ST_SHOW;
      end
      default: w_state_next = ST_SHOW;
    endcase
    if (w_step) w_state_next = LP_BLANKING ? ST_BLANK : ST_SHOW;
  end

  assign w_dwell_clear = bus.i_mode | w_step;
  assign w_dwell_en    = w_strobe & r_auto & (r_state == ST_SHOW);
  assign w_blank_clear = w_step;
  assign w_blank_en    = w_strobe & (r_state == ST_BLANK);

  frame_counter #(
    .WIDTH    (FRAME_CNT_W),
    .TERMINAL (LP_DWELL_TC)
  ) u_dwell_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_dwell_clear),
    .i_enable (w_dwell_en),
    .o_tc     (w_dwell_tc)
  );

  frame_counter #(
    .WIDTH    (FRAME_CNT_W),
    .TERMINAL (LP_BLANK_TC)
  ) u_blank_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_blank_clear),
    .i_enable (w_blank_en),
    .o_tc     (w_blank_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pattern <= LP_RESET;
      r_blank   <= 1'b0;
      r_auto    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      if (w_step) r_pattern <= step_pattern(r_pattern, w_step_dir, LP_MIN, LP_MAX);
      r_blank   <= (w_state_next == ST_BLANK);
      r_changed <= w_step;
      if (bus.i_mode) r_auto <= ~r_auto;
    end
  end

  assign bus.o_pattern = r_pattern;
  assign bus.o_blank   = r_blank;
  assign bus.o_auto    = r_auto;
  assign bus.o_changed = r_changed;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter MIN_PATTERN, default 1: lowest selectable pattern index.
REQ-002 Parameter MAX_PATTERN, default 8: highest selectable pattern index (at most 15, at least MIN_PATTERN).
REQ-003 Parameter RESET_PATTERN, default 1: pattern after reset, within MIN..MAX.
REQ-004 Parameter DWELL_FRAMES, default 120: frames each pattern is shown in auto mode (at least 1).
REQ-005 Parameter BLANK_FRAMES, default 2: black frames inserted after each change (0 disables blanking).
REQ-006 i_clk  in  1  sole clock; reset is synchronous and active-high.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_frame_strobe  in  1  one-cycle pulse per frame boundary.
REQ-009 i_next  in  1  one-cycle debounced pulse: request next pattern.
REQ-010 i_prev  in  1  one-cycle debounced pulse: request previous pattern.
REQ-011 i_mode  in  1  one-cycle debounced pulse: toggle manual/auto mode.
REQ-012 o_pattern  out  4  registered pattern index for the pattern generator.
REQ-013 o_blank  out  1  registered; high means downstream forces video black.
REQ-014 o_auto  out  1  registered; high in auto mode.
REQ-015 o_changed  out  1  one-cycle pulse in the cycle after o_pattern changes.

Function
REQ-016 The block SHALL use the states SHOW, PEND and BLANK, where PEND means a change is held until the next frame strobe.
REQ-017 In SHOW, i_next or i_prev alone SHALL record a pending direction and move to PEND, or apply at once if i_frame_strobe is high in the same cycle.
REQ-018 If i_next and i_prev are both high in one cycle, the block SHALL ignore both.
REQ-019 In PEND, a new i_next or i_prev SHALL overwrite the pending direction, and the opposite direction SHALL cancel the request and return to SHOW.
REQ-020 On i_frame_strobe in PEND, o_pattern SHALL step by +1 or -1.
  - MAX_PATTERN+1 wraps to MIN_PATTERN.
  - MIN_PATTERN-1 wraps to MAX_PATTERN.
REQ-021 The new o_pattern value SHALL be visible in the cycle after the strobe, and o_changed SHALL pulse in that same cycle.
REQ-022 After a change, the block SHALL enter BLANK with o_blank=1 when BLANK_FRAMES>0, otherwise it SHALL return to SHOW.
REQ-023 BLANK SHALL count BLANK_FRAMES strobes, counting the strobes after the one that applied the change, and SHALL return to SHOW with o_blank=0 in the cycle after the final strobe.
REQ-024 i_next and i_prev SHALL be dropped while in BLANK.
REQ-025 i_mode SHALL toggle o_auto in any state (visible next cycle) and SHALL clear the dwell counter.
REQ-026 In auto mode in SHOW, a dwell counter SHALL count strobes.
  - On the strobe that would reach DWELL_FRAMES, the pattern advances +1 with the same wrap, blank and o_changed behaviour.
  - The counter then restarts from 0.
REQ-027 A manual change in auto mode SHALL clear the dwell counter, and the dwell counter SHALL hold while in PEND or BLANK.
REQ-028 If a manual request and the dwell expiry coincide on one strobe, the manual direction SHALL win and exactly one step SHALL occur.
REQ-029 When MIN_PATTERN equals MAX_PATTERN, a step SHALL still perform the blank and pulse o_changed, with o_pattern unchanged.

Reset
REQ-030 While i_rst is high, the block SHALL hold o_pattern=RESET_PATTERN, o_blank=0, o_auto=0, o_changed=0, state SHOW, and all counters and pending requests cleared.
REQ-031 Reset asserted mid-PEND or mid-BLANK SHALL discard the operation, with no o_changed pulse.

Structure
REQ-032 State encodings and the pattern-index width (4) SHALL live in a shared video package, also used by the pattern generator.
REQ-033 A sub-module frame_counter (strobe-driven counter with clear and terminal-count flag) SHALL be instantiated twice, once for dwell and once for blank.

Verification
REQ-034 The bench SHALL cover: reset, then i_next mid-frame -> o_pattern stays 1 until the strobe, becomes 2 one cycle after it, o_changed pulses once, o_blank high for exactly 2 frames.
REQ-035 The bench SHALL cover: o_pattern=8, i_next then strobe -> 1; o_pattern=1, i_prev then strobe -> 8.
REQ-036 The bench SHALL cover: i_next and i_prev in the same cycle, then strobe -> no change, no o_changed; i_next then i_prev before the strobe -> no change.
REQ-037 The bench SHALL cover: DWELL_FRAMES=3, BLANK_FRAMES=0, i_mode, then 7 strobes -> o_pattern 1→2→3 at strobes 3 and 6, o_auto=1.
REQ-038 The bench SHALL cover: i_next during BLANK -> ignored; after the blank ends, i_next then strobe -> one step.
REQ-039 The bench SHALL cover: i_rst asserted during PEND -> o_pattern=RESET_PATTERN, later strobe -> no change.
